pipe_skid_buffer: RTL and testbench

Two-entry elastic register stage placed between pipeline stages. It drains a valid/ready producer and presents a registered valid/ready output to the consumer. Throughput is one transfer per cycle with no combinational path from out_ready to in_ready. Its job is to absorb one beat of backpressure, so the downstream stage can stall without a combinational stall chain, and to support a synchronous flush for branch/exception squash.

---
 rtl/pipe_skid_buffer_pkg.sv | 8 +
 rtl/pipe_slot.sv | 60 ++++++
 rtl/pipe_skid_buffer.sv | 125 ++++++++++++
 tb/tb_pipe_skid_buffer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_buffer_pkg.sv
// pipe_skid_buffer_pkg
//   Shared constants for the skid buffer slice.
//   STATE_W : width of the {out_valid, skid_valid} control state.
package pipe_skid_buffer_pkg;

    localparam int unsigned STATE_W = 2;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot
//   One storage slot of the skid buffer: an N-bit data register with a load
//   enable and a valid flop with set / clear / flush controls.
//   Ports:
//     clk_i    rising-edge clock
//     rst_i    asynchronous active-high reset (valid=0, data=RST_VALUE)
//     load_i   capture data_i into the data register
//     data_i   data to capture
//     set_i    mark slot valid
//     clr_i    mark slot empty
//     flush_i  mark slot empty; beats set_i and clr_i
//     valid_o  slot holds a beat
//     data_o   slot contents
module pipe_slot #(
    parameter int          N         = 32,
    parameter logic [N-1:0] RST_VALUE = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [N-1:0] data_i,
    input  logic         set_i,
    input  logic         clr_i,
    input  logic         flush_i,
    output logic         valid_o,
    output logic [N-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [N-1:0] data_q, data_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            data_d = data_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (set_i) begin
            valid_d = 1'b1;
        end else if (clr_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= RST_VALUE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer
//   Two-entry elastic register stage. The main slot drives the consumer; the
//   skid slot catches the one beat accepted while the consumer stalls. All
//   outputs come straight from flops, so there is no combinational path from
//   out_ready to in_ready.
//   Handshake: a beat moves on a port when its valid and ready are both high
//   at the rising clock edge; a valid beat is held stable until taken.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     flush                synchronous squash of all held beats
//     in_valid/in_data     producer side; in_ready back to producer
//     out_valid/out_data   head beat to consumer; out_ready from consumer
module pipe_skid_buffer
    import pipe_skid_buffer_pkg::*;
#(
    parameter int           N         = 32,
    parameter logic [N-1:0] RST_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready
);

    // State is {main valid, skid valid}; 2'b01 cannot be reached.
    localparam logic [STATE_W-1:0] ST_EMPTY = 2'b00;
    localparam logic [STATE_W-1:0] ST_ONE   = 2'b10;
    localparam logic [STATE_W-1:0] ST_FULL  = 2'b11;

    logic               main_valid, skid_valid;
    logic [N-1:0]       main_data, skid_data;
    logic [STATE_W-1:0] state;

    logic in_fire, out_fire;
    logic main_load, main_sel_skid, main_set, main_clr;
    logic skid_load, skid_set, skid_clr;
    logic [N-1:0] main_src;

    assign state    = {main_valid, skid_valid};
    assign in_ready = ~skid_valid;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid & out_ready;

    always_comb begin
        main_load     = 1'b0;
        main_sel_skid = 1'b0;
        main_set      = 1'b0;
        main_clr      = 1'b0;
        skid_load     = 1'b0;
        skid_set      = 1'b0;
        skid_clr      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    main_set  = 1'b1;
                end
            end
            ST_ONE: begin
                case ({in_fire, out_fire})
                    2'b10: begin
                        // Consumer stalled: park the new beat in skid.
                        skid_load = 1'b1;
                        skid_set  = 1'b1;
                    end
                    2'b01: main_clr  = 1'b1;
                    2'b11: main_load = 1'b1;
                    default: ;
                endcase
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_load     = 1'b1;
                    main_sel_skid = 1'b1;
                    skid_clr      = 1'b1;
                end
            end
            default: begin
                // Illegal encoding: fall back to empty.
                main_clr = 1'b1;
                skid_clr = 1'b1;
            end
        endcase
        // A squashed cycle moves no data; held data registers keep their value.
        if (flush) begin
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    assign main_src = main_sel_skid ? skid_data : in_data;

    pipe_slot #(.N(N), .RST_VALUE(RST_VALUE)) u_main (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (main_load),
        .data_i  (main_src),
        .set_i   (main_set),
        .clr_i   (main_clr),
        .flush_i (flush),
        .valid_o (main_valid),
        .data_o  (main_data)
    );

    pipe_slot #(.N(N), .RST_VALUE(RST_VALUE)) u_skid (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (skid_load),
        .data_i  (in_data),
        .set_i   (skid_set),
        .clr_i   (skid_clr),
        .flush_i (flush),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    assign out_valid = main_valid;
    assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb_pipe_skid_buffer
//   Directed scenarios followed by a long random run; every cycle is checked
//   against a queue model of at most two held beats.
module tb_pipe_skid_buffer;

  localparam int N = 32;
  localparam logic [N-1:0] RST_VALUE = '0;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         flush, in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0] in_data, out_data;

  pipe_skid_buffer #(.N(N), .RST_VALUE(RST_VALUE)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  // scoreboard / reference model
  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_head;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_head = RST_VALUE;
  endtask

  // One clock edge of the abstract buffer: up to two beats, FIFO order.
  task automatic model_step(input logic iv, input logic [N-1:0] id, input logic ordy, input logic fl);
    logic in_f, out_f;
    in_f  = iv && (exp_q.size() < 2);
    out_f = ordy && (exp_q.size() > 0);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (out_f) void'(exp_q.pop_front());
      if (in_f) exp_q.push_back(id);
      if (exp_q.size() > 0) last_head = exp_q[0];
    end
  endtask

  task automatic chk_model();
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
    chk("out_data", out_data, last_head);
    chk("state_legal", {31'b0, (!out_valid && !in_ready)}, '0);
  endtask

  // driver: apply inputs, confirm in_ready did not react, clock once, check.
  task automatic cycle(input logic iv, input logic [N-1:0] id, input logic ordy, input logic fl);
    logic r0;
    r0 = in_ready;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk("in_ready_comb", {31'b0, in_ready}, {31'b0, r0});
    @(posedge clk);
    model_step(iv, id, ordy, fl);
    #1;
    chk_model();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, '0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_data", out_data, RST_VALUE);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: full-rate stream
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, N'(i), 1'b1, 1'b0);
      chk("stream_data", out_data, N'(i));
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
      chk("stream_ready", {31'b0, in_ready}, 32'd1);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("drain_valid", {31'b0, out_valid}, '0);

    // 2: backpressure
    cycle(1'b1, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    chk("bp_in_ready", {31'b0, in_ready}, '0);
    chk("bp_head", out_data, 32'hA);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'hEE, 1'b0, 1'b0);
      chk("bp_stable_data", out_data, 32'hA);
      chk("bp_stable_valid", {31'b0, out_valid}, 32'd1);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp_second", out_data, 32'hB);
    chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp_empty", {31'b0, out_valid}, '0);

    // 3: accept and take together in ONE
    cycle(1'b1, 32'h5, 1'b0, 1'b0);
    chk("sim_head", out_data, 32'h5);
    cycle(1'b1, 32'h6, 1'b1, 1'b0);
    chk("sim_data", out_data, 32'h6);
    chk("sim_valid", {31'b0, out_valid}, 32'd1);
    chk("sim_skid_empty", {31'b0, in_ready}, 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // 4: flush while full
    cycle(1'b1, 32'h7, 1'b0, 1'b0);
    cycle(1'b1, 32'h8, 1'b0, 1'b0);
    chk("fl_full", {31'b0, in_ready}, '0);
    cycle(1'b1, 32'h9, 1'b0, 1'b1);
    chk("fl_valid", {31'b0, out_valid}, '0);
    chk("fl_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("fl_no_9", {31'b0, out_valid}, '0);
    end

    // 5: asynchronous reset mid-period while full
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h12, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_valid", {31'b0, out_valid}, '0);
    chk("arst_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_data", out_data, RST_VALUE);
    #1;
    rst = 1'b0;
    cycle(1'b1, 32'h3, 1'b1, 1'b0);
    chk("post_rst_data", out_data, 32'h3);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);

    // 6: random traffic
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
